// File: rtl/toggle_detect_gen.sv
// Per-bit toggle coverage monitor: first-toggle pulses, sticky coverage and a coverage count.
// Optional macro TOGGLE_REPORT_EVERY_EN: pulse valid on every toggle, not only the first.
module toggle_detect_gen #(
    parameter int          WIDTH       = 11,
    parameter logic [63:0] COVER_INDEX = 64'd0
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [WIDTH-1:0]           sig,
    input  logic                       sample_en,
    input  logic                       clear,
    output logic [WIDTH-1:0]           valid,
    output logic [WIDTH-1:0]           covered,
    output logic [$clog2(WIDTH+1)-1:0] cover_count,
    output logic                       all_covered,
    output logic [63:0]                cover_base
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] prev, prev_nxt;
    logic [WIDTH-1:0] toggles;
    logic [WIDTH-1:0] seen;
    logic [WIDTH-1:0] covered_nxt;
    logic [WIDTH-1:0] valid_nxt;
    logic [CW-1:0]    count_nxt;

    assign cover_base = COVER_INDEX;
    assign toggles    = sig ^ prev;
    assign seen       = covered | toggles;

    // NOTE: sequential state is written with <= so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else if (sample_en) begin
            case (state)
                IDLE:    state_nxt = ARMED;
                ARMED:   if (&seen) state_nxt = DONE;
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Next values of the registered outputs and the reference sample.
    always_comb begin
        prev_nxt    = prev;
        covered_nxt = covered;
        valid_nxt   = '0;
        if (clear) begin
            covered_nxt = '0;
        end else if (sample_en) begin
            prev_nxt = sig;
            case (state)
                ARMED: begin
                    covered_nxt = seen;
`ifdef TOGGLE_REPORT_EVERY_EN
                    valid_nxt = toggles;
`else
                    valid_nxt = toggles & ~covered;
`endif
                end
                DONE: begin
`ifdef TOGGLE_REPORT_EVERY_EN
                    valid_nxt = toggles;
`else
                    valid_nxt = '0;
`endif
                end
                default: valid_nxt = '0;
            endcase
        end
    end

    // Population count of the next coverage vector; it cannot exceed WIDTH.
    always_comb begin
        count_nxt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count_nxt = count_nxt + CW'(covered_nxt[i]);
        end
    end

    // NOTE: every register here is reset asynchronously so a reset drops any pending pulse at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev        <= '0;
            covered     <= '0;
            valid       <= '0;
            cover_count <= '0;
            all_covered <= 1'b0;
        end else begin
            prev        <= prev_nxt;
            covered     <= covered_nxt;
            valid       <= valid_nxt;
            cover_count <= count_nxt;
            all_covered <= &covered_nxt;
        end
    end

endmodule
